// File: rtl/somador_multiciclo_if.sv
// Operand/result handshake bundle for somador_multiciclo.
// Carries the optional sub line when SOMADOR_SUBTRACAO_EN is defined.
interface somador_multiciclo_if #(
    parameter int N_NIBBLES = 4
);
    localparam int W = 4 * N_NIBBLES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] resultado;
    logic         carry_out;
    logic         overflow;
`ifdef SOMADOR_SUBTRACAO_EN
    logic         sub;

    modport master (
        output in_valid, op_a, op_b, cin, sub, out_ready,
        input  in_ready, out_valid, resultado, carry_out, overflow
    );
    modport slave (
        input  in_valid, op_a, op_b, cin, sub, out_ready,
        output in_ready, out_valid, resultado, carry_out, overflow
    );
`else
    modport master (
        output in_valid, op_a, op_b, cin, out_ready,
        input  in_ready, out_valid, resultado, carry_out, overflow
    );
    modport slave (
        input  in_valid, op_a, op_b, cin, out_ready,
        output in_ready, out_valid, resultado, carry_out, overflow
    );
`endif
endinterface

// File: rtl/somador_multiciclo.sv
// Multi-cycle W-bit adder: one nibble per clock through a single somador_4bits.
// Optional subtraction (port sub) enabled by macro SOMADOR_SUBTRACAO_EN.
module somador_4bits (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] soma,
    output logic       carry_out
);
    logic [4:0] total_s;

    assign total_s   = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    assign soma      = total_s[3:0];
    assign carry_out = total_s[4];
endmodule

module somador_multiciclo #(
    parameter int N_NIBBLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    somador_multiciclo_if.slave bus
);
    localparam int W  = 4 * N_NIBBLES;
    localparam int CW = (N_NIBBLES > 1) ? $clog2(N_NIBBLES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N_NIBBLES - 1);

    typedef enum logic [1:0] {
        OCIOSO  = 2'b00,
        SOMANDO = 2'b01,
        PRONTO  = 2'b10
    } estado_t;

    estado_t       state_r;
    logic [W-1:0]  a_r;
    logic [W-1:0]  b_r;
    logic          carry_r;
    logic [CW-1:0] cnt_r;
    logic [W-1:0]  resultado_r;
    logic          carry_out_r;
    logic          overflow_r;
    logic          out_valid_r;
    logic          in_ready_r;

    logic          sub_s;
    logic          cin_init_s;
    logic [3:0]    a_nib_s;
    logic [3:0]    b_nib_s;
    logic [3:0]    soma_s;
    logic          co_s;
    logic          last_s;
    logic          ovf_s;

    // Subtraction folds into B inversion at accept plus a forced initial carry of 1.
`ifdef SOMADOR_SUBTRACAO_EN
    assign sub_s      = bus.sub;
    assign cin_init_s = bus.sub ? 1'b1 : bus.cin;
`else
    assign sub_s      = 1'b0;
    assign cin_init_s = bus.cin;
`endif

    // Nibble steering, last-nibble detect and overflow from the stored MSBs.
    always_comb begin
        a_nib_s = a_r[{cnt_r, 2'b00} +: 4];
        b_nib_s = b_r[{cnt_r, 2'b00} +: 4];
        last_s  = (cnt_r == LAST_CNT);
        ovf_s   = (a_r[W-1] == b_r[W-1]) && (soma_s[3] != a_r[W-1]);
    end

    somador_4bits u_somador (
        .a         (a_nib_s),
        .b         (b_nib_s),
        .cin       (carry_r),
        .soma      (soma_s),
        .carry_out (co_s)
    );

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= OCIOSO;
            a_r         <= {W{1'b0}};
            b_r         <= {W{1'b0}};
            carry_r     <= 1'b0;
            cnt_r       <= {CW{1'b0}};
            resultado_r <= {W{1'b0}};
            carry_out_r <= 1'b0;
            overflow_r  <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            case (state_r)
                OCIOSO: begin
                    if (bus.in_valid) begin
                        a_r        <= bus.op_a;
                        b_r        <= bus.op_b ^ {W{sub_s}};
                        carry_r    <= cin_init_s;
                        cnt_r      <= {CW{1'b0}};
                        in_ready_r <= 1'b0;
                        state_r    <= SOMANDO;
                    end
                end
                SOMANDO: begin
                    resultado_r[{cnt_r, 2'b00} +: 4] <= soma_s;
                    carry_r <= co_s;
                    if (last_s) begin
                        carry_out_r <= co_s;
                        overflow_r  <= ovf_s;
                        out_valid_r <= 1'b1;
                        state_r     <= PRONTO;
                    end else begin
                        cnt_r <= cnt_r + CW'(1'b1);
                    end
                end
                PRONTO: begin
                    // Results stay put after the handshake until the next operation.
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= OCIOSO;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= OCIOSO;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.resultado = resultado_r;
    assign bus.carry_out = carry_out_r;
    assign bus.overflow  = overflow_r;
endmodule

// File: tb/tb_somador_multiciclo.sv
// Self-checking bench for somador_multiciclo: directed vectors, stall, reset abort
// and randomized operations against an arithmetic reference model.
module tb_somador_multiciclo;
    localparam int N = 4;
    localparam int W = 4 * N;

    logic clk;
    logic rst_n;
    int   num_checks;
    int   num_errors;

    somador_multiciclo_if #(.N_NIBBLES(N)) bif ();

    somador_multiciclo #(.N_NIBBLES(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        num_checks++;
        if (obs !== exp) begin
            num_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: whole-word arithmetic, not nibble by nibble.
    function automatic logic [W+1:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic c, input logic s);
        logic [W-1:0] bb;
        logic [W:0]   full;
        logic         ov;
        bb   = s ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (s ? 1'b1 : c)};
        ov   = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
        return {ov, full};
    endfunction

    task automatic drive_sub(input logic s);
`ifdef SOMADOR_SUBTRACAO_EN
        bif.sub = s;
`else
        if (s) $display("note: sub requested in add-only build");
`endif
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input logic s, input int hold,
                         output logic [W-1:0] res, output logic co, output logic ov);
        int cyc;
        logic [W+1:0] exp;
        exp = ref_model(a, b, c, s);
        cyc = 0;
        while (!bif.in_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check_val("in_ready_idle", 32'(bif.in_ready), 32'd1);
        bif.op_a = a;
        bif.op_b = b;
        bif.cin  = c;
        drive_sub(s);
        bif.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bif.in_valid = 1'b0;
        bif.op_a = W'($urandom);
        bif.op_b = W'($urandom);
        bif.cin  = 1'($urandom);
        drive_sub(1'b0);
        check_val("in_ready_busy", 32'(bif.in_ready), 32'd0);
        cyc = 0;
        while (!bif.out_valid && cyc < N + 5) begin
            @(negedge clk);
            cyc++;
        end
        check_val("latency", 32'(cyc), 32'(N));
        res = bif.resultado;
        co  = bif.carry_out;
        ov  = bif.overflow;
        check_val("resultado", 32'(res), 32'(exp[W-1:0]));
        check_val("carry_out", 32'(co), 32'(exp[W]));
        check_val("overflow", 32'(ov), 32'(exp[W+1]));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_val("hold_valid", 32'(bif.out_valid), 32'd1);
            check_val("hold_in_ready", 32'(bif.in_ready), 32'd0);
            check_val("hold_res", 32'({bif.overflow, bif.carry_out, bif.resultado}),
                      32'({ov, co, res}));
        end
        bif.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bif.out_ready = 1'b0;
        check_val("valid_drop", 32'(bif.out_valid), 32'd0);
        check_val("in_ready_back", 32'(bif.in_ready), 32'd1);
        check_val("res_kept", 32'(bif.resultado), 32'(res));
    endtask

    initial begin
        logic [W-1:0] r;
        logic         co;
        logic         ov;
        int           cyc;
        num_checks = 0;
        num_errors = 0;
        rst_n = 1'b0;
        bif.in_valid = 1'b0;
        bif.out_ready = 1'b0;
        bif.op_a = '0;
        bif.op_b = '0;
        bif.cin = 1'b0;
        drive_sub(1'b0);
        repeat (3) @(negedge clk);
        check_val("rst_in_ready", 32'(bif.in_ready), 32'd1);
        check_val("rst_out_valid", 32'(bif.out_valid), 32'd0);
        check_val("rst_res", 32'({bif.overflow, bif.carry_out, bif.resultado}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(16'h1234, 16'h0FCD, 1'b0, 1'b0, 0, r, co, ov);
        check_val("vec1", 32'({ov, co, r}), 32'h0_2201);
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, r, co, ov);
        check_val("vec2", 32'({ov, co, r}), 32'h1_0000);
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, r, co, ov);
        check_val("vec3", 32'({ov, co, r}), 32'h2_8000);
        do_op(16'h0000, 16'h0000, 1'b1, 1'b0, 0, r, co, ov);
        check_val("vec4", 32'({ov, co, r}), 32'h0_0001);
`ifdef SOMADOR_SUBTRACAO_EN
        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0, r, co, ov);
        check_val("vec_sub", 32'({ov, co, r}), 32'h0_FFFE);
`endif
        do_op(16'h1234, 16'h0FCD, 1'b0, 1'b0, 5, r, co, ov);

        // Abort in the second SOMANDO cycle.
        bif.op_a = 16'hABCD;
        bif.op_b = 16'h1111;
        bif.cin = 1'b0;
        bif.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bif.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("abort_in_ready", 32'(bif.in_ready), 32'd1);
        check_val("abort_out_valid", 32'(bif.out_valid), 32'd0);
        check_val("abort_res", 32'({bif.overflow, bif.carry_out, bif.resultado}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        for (int i = 0; i < N + 3; i++) begin
            @(negedge clk);
            if (bif.out_valid) cyc++;
        end
        check_val("abort_no_result", 32'(cyc), 32'd0);
        do_op(16'h4321, 16'h1111, 1'b1, 1'b0, 1, r, co, ov);

        for (int k = 0; k < 24; k++) begin
`ifdef SOMADOR_SUBTRACAO_EN
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 2),
                  r, co, ov);
`else
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, $urandom_range(0, 2),
                  r, co, ov);
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end
endmodule
